// File: rtl/p3_buf_sched_if.sv
// Handshake and select bundle between the ping/pang/pong buffer scheduler
// and its agents (snooper, CPU, forwarder) plus the downstream muxes stage.
interface p3_buf_sched_if;
    logic       sn_done;
    logic       sn_rdy;
    logic       cpu_acc;
    logic       cpu_rej;
    logic       cpu_rdy;
    logic       fwd_done;
    logic       fwd_rdy;
    logic [1:0] sn_sel;
    logic [1:0] cpu_sel;
    logic [1:0] fwd_sel;
    logic [1:0] ping_sel;
    logic [1:0] pang_sel;
    logic [1:0] pong_sel;

    // Agent / environment side: drives the done/accept/reject pulses.
    modport master (
        output sn_done, cpu_acc, cpu_rej, fwd_done,
        input  sn_rdy, cpu_rdy, fwd_rdy,
        input  sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel, pong_sel
    );

    // Scheduler side.
    modport slave (
        input  sn_done, cpu_acc, cpu_rej, fwd_done,
        output sn_rdy, cpu_rdy, fwd_rdy,
        output sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel, pong_sel
    );
endinterface

// File: rtl/p3_buf_sched.sv
// Ownership scheduler for the three packet buffers (ping, pang, pong).
// Each buffer walks FREE -> SN -> WAIT_CPU -> CPU -> WAIT_FWD -> FWD -> FREE,
// or CPU -> DROP -> FREE on reject. Each agent follows its own rotating
// pointer, so packet order is preserved.
// Optional feature: define P3_BUF_SCHED_DROP_CNT_EN to add the saturating
// drop_cnt output counting honoured rejects.
// All outputs are registered; they are computed from the next-state values
// so grant timing is the same as decoding directly from the state registers.
module p3_buf_sched #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    p3_buf_sched_if.slave        bus
`ifdef P3_BUF_SCHED_DROP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] drop_cnt
`endif
);

    localparam logic [2:0] ST_FREE     = 3'd0;
    localparam logic [2:0] ST_SN       = 3'd1;
    localparam logic [2:0] ST_WAIT_CPU = 3'd2;
    localparam logic [2:0] ST_CPU      = 3'd3;
    localparam logic [2:0] ST_WAIT_FWD = 3'd4;
    localparam logic [2:0] ST_FWD      = 3'd5;
    localparam logic [2:0] ST_DROP     = 3'd6;

    localparam logic [1:0] SEL_NONE    = 2'b11;

    // Buffer index 0 = ping, 1 = pang, 2 = pong.
    logic [2:0][2:0] buf_st_r;
    logic [2:0][2:0] buf_st_s;
    logic [1:0]      sn_ptr_r,  sn_ptr_s;
    logic [1:0]      cpu_ptr_r, cpu_ptr_s;
    logic [1:0]      fwd_ptr_r, fwd_ptr_s;
    logic            sn_adv_s, cpu_adv_s, fwd_adv_s, rej_hit_s;

    logic            sn_rdy_r,  cpu_rdy_r,  fwd_rdy_r;
    logic [1:0]      sn_sel_r,  cpu_sel_r,  fwd_sel_r;
    logic [1:0]      ping_sel_r, pang_sel_r, pong_sel_r;
    logic [1:0]      sn_sel_s,  cpu_sel_s,  fwd_sel_s;
    logic [1:0]      ping_sel_s, pang_sel_s, pong_sel_s;

    // Rotate ping -> pang -> pong -> ping.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        case (ptr)
            2'd0:    ptr_inc = 2'd1;
            2'd1:    ptr_inc = 2'd2;
            default: ptr_inc = 2'd0;
        endcase
    endfunction

    // Which agent drives a buffer, from the buffer's state.
    function automatic logic [1:0] owner_of(input logic [2:0] st);
        case (st)
            ST_SN:   owner_of = 2'b00;
            ST_CPU:  owner_of = 2'b01;
            ST_FWD:  owner_of = 2'b10;
            default: owner_of = SEL_NONE;
        endcase
    endfunction

    // Buffer held by an agent: its pointed-to buffer if in the owned state.
    function automatic logic [1:0] agent_sel(input logic [2:0][2:0] st,
                                             input logic [1:0]      ptr,
                                             input logic [2:0]      own);
        case (ptr)
            2'd0:    agent_sel = (st[0] == own) ? 2'd0 : SEL_NONE;
            2'd1:    agent_sel = (st[1] == own) ? 2'd1 : SEL_NONE;
            2'd2:    agent_sel = (st[2] == own) ? 2'd2 : SEL_NONE;
            default: agent_sel = SEL_NONE;
        endcase
    endfunction

    // Per-buffer next state; each state is touched by exactly one agent,
    // so the three agents never write the same buffer in one cycle.
    always_comb begin
        buf_st_s  = buf_st_r;
        sn_adv_s  = 1'b0;
        cpu_adv_s = 1'b0;
        fwd_adv_s = 1'b0;
        rej_hit_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            case (buf_st_r[i])
                ST_FREE: begin
                    if (sn_ptr_r == 2'(i)) buf_st_s[i] = ST_SN;
                    else                   buf_st_s[i] = ST_FREE;
                end
                ST_SN: begin
                    if (bus.sn_done && (sn_ptr_r == 2'(i))) begin
                        buf_st_s[i] = ST_WAIT_CPU;
                        sn_adv_s    = 1'b1;
                    end else begin
                        buf_st_s[i] = ST_SN;
                    end
                end
                ST_WAIT_CPU: begin
                    if (cpu_ptr_r == 2'(i)) buf_st_s[i] = ST_CPU;
                    else                    buf_st_s[i] = ST_WAIT_CPU;
                end
                ST_CPU: begin
                    // Reject has priority over a simultaneous accept.
                    if (bus.cpu_rej && (cpu_ptr_r == 2'(i))) begin
                        buf_st_s[i] = ST_DROP;
                        cpu_adv_s   = 1'b1;
                        rej_hit_s   = 1'b1;
                    end else if (bus.cpu_acc && (cpu_ptr_r == 2'(i))) begin
                        buf_st_s[i] = ST_WAIT_FWD;
                        cpu_adv_s   = 1'b1;
                    end else begin
                        buf_st_s[i] = ST_CPU;
                    end
                end
                ST_WAIT_FWD: begin
                    if (fwd_ptr_r == 2'(i)) buf_st_s[i] = ST_FWD;
                    else                    buf_st_s[i] = ST_WAIT_FWD;
                end
                ST_FWD: begin
                    if (bus.fwd_done && (fwd_ptr_r == 2'(i))) begin
                        buf_st_s[i] = ST_FREE;
                        fwd_adv_s   = 1'b1;
                    end else begin
                        buf_st_s[i] = ST_FWD;
                    end
                end
                ST_DROP: begin
                    // Forwarder spends one cycle skipping a rejected buffer.
                    if (fwd_ptr_r == 2'(i)) begin
                        buf_st_s[i] = ST_FREE;
                        fwd_adv_s   = 1'b1;
                    end else begin
                        buf_st_s[i] = ST_DROP;
                    end
                end
                default: buf_st_s[i] = ST_FREE;
            endcase
        end
    end

    // Agent pointer advance on release.
    always_comb begin
        if (sn_adv_s)  sn_ptr_s  = ptr_inc(sn_ptr_r);
        else           sn_ptr_s  = sn_ptr_r;
        if (cpu_adv_s) cpu_ptr_s = ptr_inc(cpu_ptr_r);
        else           cpu_ptr_s = cpu_ptr_r;
        if (fwd_adv_s) fwd_ptr_s = ptr_inc(fwd_ptr_r);
        else           fwd_ptr_s = fwd_ptr_r;
    end

    // Select decode from the next state, fed into the output registers.
    always_comb begin
        sn_sel_s   = agent_sel(buf_st_s, sn_ptr_s,  ST_SN);
        cpu_sel_s  = agent_sel(buf_st_s, cpu_ptr_s, ST_CPU);
        fwd_sel_s  = agent_sel(buf_st_s, fwd_ptr_s, ST_FWD);
        ping_sel_s = owner_of(buf_st_s[0]);
        pang_sel_s = owner_of(buf_st_s[1]);
        pong_sel_s = owner_of(buf_st_s[2]);
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_st_r  <= {ST_FREE, ST_FREE, ST_FREE};
            sn_ptr_r  <= 2'd0;
            cpu_ptr_r <= 2'd0;
            fwd_ptr_r <= 2'd0;
        end else begin
            buf_st_r  <= buf_st_s;
            sn_ptr_r  <= sn_ptr_s;
            cpu_ptr_r <= cpu_ptr_s;
            fwd_ptr_r <= fwd_ptr_s;
        end
    end

    // Output registers; ready is simply "agent holds a buffer".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sn_sel_r   <= SEL_NONE;
            cpu_sel_r  <= SEL_NONE;
            fwd_sel_r  <= SEL_NONE;
            ping_sel_r <= SEL_NONE;
            pang_sel_r <= SEL_NONE;
            pong_sel_r <= SEL_NONE;
            sn_rdy_r   <= 1'b0;
            cpu_rdy_r  <= 1'b0;
            fwd_rdy_r  <= 1'b0;
        end else begin
            sn_sel_r   <= sn_sel_s;
            cpu_sel_r  <= cpu_sel_s;
            fwd_sel_r  <= fwd_sel_s;
            ping_sel_r <= ping_sel_s;
            pang_sel_r <= pang_sel_s;
            pong_sel_r <= pong_sel_s;
            sn_rdy_r   <= (sn_sel_s  != SEL_NONE);
            cpu_rdy_r  <= (cpu_sel_s != SEL_NONE);
            fwd_rdy_r  <= (fwd_sel_s != SEL_NONE);
        end
    end

    assign bus.sn_sel   = sn_sel_r;
    assign bus.cpu_sel  = cpu_sel_r;
    assign bus.fwd_sel  = fwd_sel_r;
    assign bus.ping_sel = ping_sel_r;
    assign bus.pang_sel = pang_sel_r;
    assign bus.pong_sel = pong_sel_r;
    assign bus.sn_rdy   = sn_rdy_r;
    assign bus.cpu_rdy  = cpu_rdy_r;
    assign bus.fwd_rdy  = fwd_rdy_r;

`ifdef P3_BUF_SCHED_DROP_CNT_EN
    logic [CNT_WIDTH-1:0] drop_cnt_r;

    // Saturating count of honoured rejects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (rej_hit_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

endmodule
